// File: rtl/gon_gather_initiator_pkg.sv
// Shared definitions for the GON X-bus gather initiator: default widths and FSM states.
package gon_gather_initiator_pkg;

  localparam int ID_LEN_DEF     = 5;
  localparam int VALUE_LEN_DEF  = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_LEN_DEF    = 6;
  localparam int STALL_LEN      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POLL = 2'd1,
    ST_FIN  = 2'd2
  } gather_state_e;

endpackage

// File: rtl/gon_sync_fifo.sv
// First-word-fall-through FIFO on registered storage; the head holds the last popped word
// while empty so downstream sees a stable value.
module gon_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // NOTE: storage has no reset; count_q gates visibility so stale words never reach the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : last_q;
  assign count_o      = count_q;

endmodule

// File: rtl/gon_gather_initiator.sv
// Initiator end of the GON X-bus gather: polls a tag range, buffers each enabled value with
// its tag, and streams the pairs to the GLB writer over valid/ready.
module gon_gather_initiator
  import gon_gather_initiator_pkg::*;
#(
  parameter int ID_LEN     = ID_LEN_DEF,
  parameter int VALUE_LEN  = VALUE_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_LEN    = CNT_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ID_LEN-1:0]    tag_base,
  input  logic [CNT_LEN-1:0]   tag_count,
  output logic                 busy,
  output logic                 done,
  output logic [ID_LEN:0]      ready_tag,
  input  logic [VALUE_LEN:0]   enable_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VALUE_LEN-1:0] out_data,
  output logic [ID_LEN-1:0]    out_tag,
  output logic [STALL_LEN-1:0] stall_cycles
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ID_LEN + VALUE_LEN;

  gather_state_e        state_q, state_d;
  logic [ID_LEN-1:0]    cur_tag_q, cur_tag_d;
  logic [CNT_LEN-1:0]   rem_q, rem_d;
  logic [STALL_LEN-1:0] stall_q, stall_d;
  logic [CW-1:0]        fifo_count;
  logic [EW-1:0]        head_data;
  logic                 ready, accept;

  // Ready depends only on registered state so the bus never sees a path from out_ready.
  assign ready  = (state_q == ST_POLL) && (fifo_count < CW'(FIFO_DEPTH));
  assign accept = ready && enable_value[VALUE_LEN];

  // NOTE: every _d gets its hold value first, so no path can leave a latch behind.
  always_comb begin
    state_d   = state_q;
    cur_tag_d = cur_tag_q;
    rem_d     = rem_q;
    stall_d   = stall_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_tag_d = tag_base;
          rem_d     = tag_count;
          stall_d   = '0;
          state_d   = (tag_count != '0) ? ST_POLL : ST_FIN;
        end
      end
      ST_POLL: begin
        if (accept) begin
          cur_tag_d = cur_tag_q + ID_LEN'(1);
          rem_d     = rem_q - CNT_LEN'(1);
          if (rem_q == CNT_LEN'(1)) state_d = ST_FIN;
        end else if (ready && (stall_q != '1)) begin
          stall_d = stall_q + STALL_LEN'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_tag_q <= '0;
      rem_q     <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_tag_q <= cur_tag_d;
      rem_q     <= rem_d;
      stall_q   <= stall_d;
    end
  end

  gon_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (accept),
    .push_data_i  ({cur_tag_q, enable_value[VALUE_LEN-1:0]}),
    .pop_i        (out_ready),
    .head_valid_o (out_valid),
    .head_data_o  (head_data),
    .count_o      (fifo_count)
  );

  assign out_tag      = head_data[EW-1:VALUE_LEN];
  assign out_data     = head_data[VALUE_LEN-1:0];
  assign ready_tag    = {ready, cur_tag_q};
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_gon_gather_initiator.sv
// Self-checking bench for gon_gather_initiator: directed table, corner sequences and random runs
// against a transaction-level model (expected tag stream, buffered pairs, stall count).
module tb_gon_gather_initiator;

  localparam int ID    = 5;
  localparam int VL    = 32;
  localparam int DEPTH = 4;
  localparam int CL    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [ID-1:0] tag_base = '0;
  logic [CL-1:0] tag_count = '0;
  logic          busy, done, out_valid;
  logic [ID:0]   ready_tag;
  logic [VL:0]   enable_value = '0;
  logic          out_ready = 1'b0;
  logic [VL-1:0] out_data;
  logic [ID-1:0] out_tag;
  logic [15:0]   stall_cycles;

  gon_gather_initiator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tag_base     (tag_base),
    .tag_count    (tag_count),
    .busy         (busy),
    .done         (done),
    .ready_tag    (ready_tag),
    .enable_value (enable_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a run is "polling" while tags remain; the buffer holds pairs
  // accepted but not yet taken by the writer.
  bit             m_poll, m_fin;
  logic [ID-1:0]  m_tag;
  int             m_rem;
  int             m_stall;
  logic [ID+VL-1:0] m_q[$];
  logic [VL-1:0]  m_last_data;
  logic [ID-1:0]  m_last_tag;
  int             pops_run;
  logic [ID-1:0]  first_tag_run, last_tag_run;

  function automatic bit idle_and_empty();
    return !m_poll && !m_fin && (m_q.size() == 0);
  endfunction

  // One clock cycle: check visible outputs, drive inputs, advance the model, step the clock.
  task automatic cycle(input bit st, input logic [ID-1:0] b, input logic [CL-1:0] c,
                       input bit en, input bit ordy);
    bit exp_rdy, acc, nxt_poll, nxt_fin;
    logic [VL-1:0] v;
    logic [ID+VL-1:0] head;
    exp_rdy = m_poll && (m_q.size() < DEPTH);
    check("ready_bit", ready_tag[ID], exp_rdy);
    if (exp_rdy) check("poll_tag", ready_tag[ID-1:0], m_tag);
    check("busy", busy, m_poll || m_fin);
    check("done", done, m_fin);
    check("out_valid", out_valid, m_q.size() > 0);
    check("stall_cycles", stall_cycles, m_stall);
    if (m_q.size() == 0) begin
      check("hold_data", out_data, m_last_data);
      check("hold_tag", out_tag, m_last_tag);
    end
    v = $urandom();
    start        = st;
    tag_base     = b;
    tag_count    = c;
    out_ready    = ordy;
    enable_value = {en, v};
    acc = exp_rdy && en;
    if ((m_q.size() > 0) && ordy) begin
      head = m_q.pop_front();
      check("out_tag", out_tag, head[ID+VL-1:VL]);
      check("out_data", out_data, head[VL-1:0]);
      m_last_tag  = head[ID+VL-1:VL];
      m_last_data = head[VL-1:0];
      if (pops_run == 0) first_tag_run = m_last_tag;
      last_tag_run = m_last_tag;
      pops_run++;
    end
    nxt_poll = m_poll;
    nxt_fin  = 1'b0;
    if (acc) begin
      m_q.push_back({m_tag, v});
      m_tag = m_tag + 1'b1;
      m_rem--;
      if (m_rem == 0) begin
        nxt_poll = 1'b0;
        nxt_fin  = 1'b1;
      end
    end else if (exp_rdy && m_stall < 65535) begin
      m_stall++;
    end
    if (st && !m_poll && !m_fin) begin
      m_tag    = b;
      m_rem    = c;
      m_stall  = 0;
      nxt_poll = (c != 0);
      nxt_fin  = (c == 0);
    end
    m_poll = nxt_poll;
    m_fin  = nxt_fin;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_reset(input bit verify);
    rst = 1'b1;
    start = 1'b0;
    enable_value = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    if (verify) begin
      check("rst_ready_tag", ready_tag, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_stall", stall_cycles, 0);
    end
    rst = 1'b0;
    m_poll = 0; m_fin = 0; m_tag = '0; m_rem = 0; m_stall = 0;
    m_q.delete();
    m_last_data = '0; m_last_tag = '0;
  endtask

  // Drain with bus always enabling and writer always ready; bounded.
  task automatic finish_run(input string name);
    int k;
    for (k = 0; k < 200 && !idle_and_empty(); k++) cycle(1'b0, '0, '0, 1'b1, 1'b1);
    check({name, "_completes"}, idle_and_empty(), 1);
  endtask

  typedef struct {
    logic [ID-1:0] base;
    logic [CL-1:0] cnt;
    int            exp_done_at;
    logic [ID-1:0] exp_first;
    logic [ID-1:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int done_at;
    tbl[0] = '{base: 5'd3,  cnt: 6'd4, exp_done_at: 5, exp_first: 5'd3,  exp_last: 5'd6};
    tbl[1] = '{base: 5'd30, cnt: 6'd4, exp_done_at: 5, exp_first: 5'd30, exp_last: 5'd1};
    tbl[2] = '{base: 5'd0,  cnt: 6'd1, exp_done_at: 2, exp_first: 5'd0,  exp_last: 5'd0};
    tbl[3] = '{base: 5'd31, cnt: 6'd2, exp_done_at: 3, exp_first: 5'd31, exp_last: 5'd0};
    tbl[4] = '{base: 5'd9,  cnt: 6'd0, exp_done_at: 1, exp_first: 5'd0,  exp_last: 5'd0};

    do_reset(1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Directed table: bus always enables, writer always ready.
    for (int i = 0; i < 5; i++) begin
      pops_run = 0;
      done_at  = -1;
      cycle(1'b1, tbl[i].base, tbl[i].cnt, 1'b1, 1'b1);
      for (int k = 1; k < 100; k++) begin
        if (done && done_at < 0) done_at = k;
        if (done_at >= 0 && idle_and_empty() && !busy) break;
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
      end
      check("tbl_done_at", done_at, tbl[i].exp_done_at);
      check("tbl_pops", pops_run, tbl[i].cnt);
      if (tbl[i].cnt != 0) begin
        check("tbl_first_tag", first_tag_run, tbl[i].exp_first);
        check("tbl_last_tag", last_tag_run, tbl[i].exp_last);
      end
    end

    // Writer back-pressure: FIFO fills, ready drops with tag held at 7, then resumes.
    pops_run = 0;
    cycle(1'b1, 5'd3, 6'd6, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_ready_tag", ready_tag, {1'b0, 5'd7});
    check("bp_out_valid", out_valid, 1);
    finish_run("bp");
    check("bp_pops", pops_run, 6);
    check("bp_last_tag", last_tag_run, 5'd8);

    // Enable withheld 5 cycles on tag 2.
    pops_run = 0;
    cycle(1'b1, 5'd2, 6'd3, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("stall_ready_tag", ready_tag, {1'b1, 5'd2});
    check("stall_count", stall_cycles, 5);
    finish_run("stall");
    check("stall_pops", pops_run, 3);
    check("stall_after_run", stall_cycles, 5);

    // Start during polling is ignored.
    pops_run = 0;
    cycle(1'b1, 5'd0, 6'd3, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 5'd20, 6'd1, 1'b0, 1'b1);
    check("ignored_start_tag", ready_tag, {1'b1, 5'd0});
    finish_run("ignore");
    check("ignore_pops", pops_run, 3);
    check("ignore_last_tag", last_tag_run, 5'd2);

    // Reset mid-run with two words buffered.
    cycle(1'b1, 5'd0, 6'd6, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("pre_rst_buffered", out_valid, 1);
    do_reset(1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);

    // Randomized runs, with stray starts that may land in IDLE and append to the buffer.
    for (int r = 0; r < 25; r++) begin
      int k;
      cycle(1'b1, ID'($urandom()), CL'($urandom_range(0, 20)), 1'b1, 1'($urandom_range(0, 1)));
      for (k = 0; k < 2000 && !idle_and_empty(); k++) begin
        cycle(($urandom_range(0, 99) < 4), ID'($urandom()), CL'($urandom_range(0, 8)),
              ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60));
      end
      check("rand_run_completes", idle_and_empty(), 1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        cycle(1'b0, '0, '0, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
